// File: rtl/flash_arb_pkg.sv
// Shared types and constants for the flash SPI arbiter.
//   flash_arb_state_t : arbiter FSM states (IDLE, SETUP, ACTIVE, DRAIN, RELEASE)
//   FLASH_ARB_MAX_REQ : largest supported number of requesters
package flash_arb_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SETUP   = 3'd1,
        ST_ACTIVE  = 3'd2,
        ST_DRAIN   = 3'd3,
        ST_RELEASE = 3'd4
    } flash_arb_state_t;

    localparam int FLASH_ARB_MAX_REQ = 8;

endpackage

// File: rtl/flash_spi_arbiter_rr_pick.sv
// rr_pick: combinational round-robin selector.
// Searches the eligible vector starting at last_i+1 and wrapping at
// NUM_REQ-1, so the most recent winner gets lowest priority.
//   elig_i  : per-requester eligibility
//   last_i  : index of the previous winner
//   idx_o   : winning index (0 when nothing is eligible)
//   valid_o : at least one requester is eligible
module rr_pick
    import flash_arb_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] elig_i,
    input  logic [IDX_W-1:0]   last_i,
    output logic [IDX_W-1:0]   idx_o,
    output logic               valid_o
);

    localparam logic [IDX_W-1:0] TOP_IDX = IDX_W'(NUM_REQ - 1);
    localparam logic [IDX_W-1:0] IDX_ONE = IDX_W'(1);

    logic [IDX_W-1:0] cand;
    logic             found;

    always_comb begin
        idx_o = '0;
        found = 1'b0;
        // Explicit wrap so non-power-of-two NUM_REQ never visits a bad index.
        cand  = (last_i == TOP_IDX) ? '0 : last_i + IDX_ONE;
        for (int k = 0; k < FLASH_ARB_MAX_REQ; k++) begin
            if (k < NUM_REQ) begin
                if (!found && elig_i[cand]) begin
                    idx_o = cand;
                    found = 1'b1;
                end
                cand = (cand == TOP_IDX) ? '0 : cand + IDX_ONE;
            end
        end
        valid_o = found;
    end

endmodule

// File: rtl/flash_spi_arbiter.sv
// flash_spi_arbiter: shares one SPI byte engine and the flash chip-select
// between NUM_REQ requesters, one whole CSB transaction at a time.
//   req_i/gnt_o        : per-requester ownership handshake (gnt one-hot)
//   start_i/out_i      : per-requester byte start and TX byte
//   done_o/timeout_o   : byte-complete (owner only) / forced-release pulse
//   in_o               : RX byte, broadcast from spi_in_i
//   spi_*              : SPI byte engine interface
//   flash_csb_o        : flash chip-select, active-low, driven only here
module flash_spi_arbiter
    import flash_arb_pkg::*;
#(
    parameter int NUM_REQ  = 2,
    parameter int CS_SETUP = 1,
    parameter int CS_HOLD  = 2,
    parameter int TIMEOUT  = 1024
) (
    input  logic                 clk_i,
    input  logic                 reset_ni,
    input  logic [NUM_REQ-1:0]   req_i,
    output logic [NUM_REQ-1:0]   gnt_o,
    input  logic [NUM_REQ-1:0]   start_i,
    input  logic [8*NUM_REQ-1:0] out_i,
    output logic [7:0]           in_o,
    output logic [NUM_REQ-1:0]   done_o,
    output logic [NUM_REQ-1:0]   timeout_o,
    output logic                 spi_start_o,
    output logic [7:0]           spi_out_o,
    input  logic [7:0]           spi_in_i,
    input  logic                 spi_done_i,
    input  logic                 spi_busy_i,
    output logic                 flash_csb_o
);

    localparam int OW   = $clog2(NUM_REQ);
    localparam int MAXV = (CS_SETUP > CS_HOLD)
                        ? ((CS_SETUP > TIMEOUT) ? CS_SETUP : TIMEOUT)
                        : ((CS_HOLD  > TIMEOUT) ? CS_HOLD  : TIMEOUT);
    localparam int CW   = $clog2(MAXV + 1);

    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_MAX  = '1;
    localparam logic [CW-1:0] CNT_SET  = CW'(CS_SETUP);
    localparam logic [CW-1:0] CNT_HOLD = CW'(CS_HOLD);
    localparam logic [CW-1:0] CNT_TMO  = CW'(TIMEOUT);

    flash_arb_state_t   state_q, state_d;
    logic [OW-1:0]      owner_q, owner_d;
    logic [OW-1:0]      last_q, last_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [CW-1:0]      idle_q, idle_d;
    logic               pending_q, pending_d;
    logic [NUM_REQ-1:0] mask_q, mask_d;

    logic [NUM_REQ-1:0] elig;
    logic [OW-1:0]      pick_idx;
    logic               pick_vld;

    logic               own_req;
    logic               pend_eff;
    logic               tmo_hit;
    logic               fwd;
    int                 own_i;

    assign elig = req_i & ~mask_q;
    assign in_o = spi_in_i;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (OW)
    ) u_rr_pick (
        .elig_i  (elig),
        .last_i  (last_q),
        .idx_o   (pick_idx),
        .valid_o (pick_vld)
    );

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q   <= ST_IDLE;
            owner_q   <= '0;
            last_q    <= OW'(NUM_REQ - 1);
            cnt_q     <= '0;
            idle_q    <= '0;
            pending_q <= 1'b0;
            mask_q    <= '0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            last_q    <= last_d;
            cnt_q     <= cnt_d;
            idle_q    <= idle_d;
            pending_q <= pending_d;
            mask_q    <= mask_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        last_d      = last_q;
        cnt_d       = cnt_q;
        idle_d      = idle_q;
        pending_d   = pending_q;
        mask_d      = mask_q & req_i;
        gnt_o       = '0;
        done_o      = '0;
        timeout_o   = '0;
        spi_start_o = 1'b0;
        spi_out_o   = '0;
        flash_csb_o = 1'b1;
        fwd         = 1'b0;

        own_i    = int'(owner_q);
        own_req  = req_i[owner_q];
        // A done arriving this cycle frees the engine for a same-cycle start.
        pend_eff = pending_q & ~spi_done_i;
        // Owner dropping req takes priority over the timeout.
        tmo_hit  = (TIMEOUT != 0) && (idle_q >= CNT_TMO) && own_req;

        unique case (state_q)
            ST_IDLE: begin
                if (pick_vld) begin
                    owner_d = pick_idx;
                    last_d  = pick_idx;
                    cnt_d   = CNT_SET;
                    state_d = ST_SETUP;
                end
            end

            ST_SETUP: begin
                flash_csb_o = 1'b0;
                if (cnt_q <= CNT_ONE) begin
                    idle_d  = '0;
                    state_d = ST_ACTIVE;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end

            ST_ACTIVE: begin
                flash_csb_o      = 1'b0;
                gnt_o[owner_q]   = 1'b1;
                spi_out_o        = out_i[8*own_i +: 8];
                done_o[owner_q]  = spi_done_i & pending_q;
                // No start on the cycle the bus is being taken away.
                fwd              = start_i[owner_q] & ~pend_eff & ~spi_busy_i & ~tmo_hit;
                spi_start_o      = fwd;
                pending_d        = pend_eff | fwd;

                if (pending_q || fwd) begin
                    idle_d = '0;
                end else if (idle_q != CNT_MAX) begin
                    idle_d = idle_q + CNT_ONE;
                end

                if (!own_req) begin
                    cnt_d   = CNT_HOLD;
                    state_d = pending_d ? ST_DRAIN : ST_RELEASE;
                end else if (tmo_hit) begin
                    timeout_o[owner_q] = 1'b1;
                    mask_d[owner_q]    = 1'b1;
                    cnt_d              = CNT_HOLD;
                    state_d            = ST_RELEASE;
                end
            end

            ST_DRAIN: begin
                flash_csb_o     = 1'b0;
                done_o[owner_q] = spi_done_i & pending_q;
                if (spi_done_i) begin
                    pending_d = 1'b0;
                    cnt_d     = CNT_HOLD;
                    state_d   = ST_RELEASE;
                end
            end

            ST_RELEASE: begin
                // The final hold cycle also arbitrates, so back-to-back
                // transactions see CSB high for exactly CS_HOLD cycles.
                if (cnt_q <= CNT_ONE) begin
                    if (pick_vld) begin
                        owner_d = pick_idx;
                        last_d  = pick_idx;
                        cnt_d   = CNT_SET;
                        state_d = ST_SETUP;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_flash_spi_arbiter.sv
// Directed bench for flash_spi_arbiter (NUM_REQ=2, CS_SETUP=1, CS_HOLD=2,
// TIMEOUT=8). The bench plays the SPI byte engine by driving spi_busy_i and
// spi_done_i by hand. Inputs change 1 ns after the rising edge and outputs
// are sampled 1 ns later, well away from the next edge.
module tb_flash_spi_arbiter;

    localparam int NUM_REQ  = 2;
    localparam int CS_SETUP = 1;
    localparam int CS_HOLD  = 2;
    localparam int TIMEOUT  = 8;

    logic        clk_i = 1'b0;
    logic        reset_ni;
    logic [1:0]  req_i;
    logic [1:0]  gnt_o;
    logic [1:0]  start_i;
    logic [15:0] out_i;
    logic [7:0]  in_o;
    logic [1:0]  done_o;
    logic [1:0]  timeout_o;
    logic        spi_start_o;
    logic [7:0]  spi_out_o;
    logic [7:0]  spi_in_i;
    logic        spi_done_i;
    logic        spi_busy_i;
    logic        flash_csb_o;

    int n_vec = 0;
    int n_err = 0;

    logic [7:0] bytes_t1 [4];

    flash_spi_arbiter #(
        .NUM_REQ  (NUM_REQ),
        .CS_SETUP (CS_SETUP),
        .CS_HOLD  (CS_HOLD),
        .TIMEOUT  (TIMEOUT)
    ) dut (
        .clk_i       (clk_i),
        .reset_ni    (reset_ni),
        .req_i       (req_i),
        .gnt_o       (gnt_o),
        .start_i     (start_i),
        .out_i       (out_i),
        .in_o        (in_o),
        .done_o      (done_o),
        .timeout_o   (timeout_o),
        .spi_start_o (spi_start_o),
        .spi_out_o   (spi_out_o),
        .spi_in_i    (spi_in_i),
        .spi_done_i  (spi_done_i),
        .spi_busy_i  (spi_busy_i),
        .flash_csb_o (flash_csb_o)
    );

    initial forever #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        bytes_t1[0] = 8'h03;
        bytes_t1[1] = 8'h00;
        bytes_t1[2] = 8'h00;
        bytes_t1[3] = 8'h00;

        reset_ni   = 1'b0;
        req_i      = 2'b00;
        start_i    = 2'b00;
        out_i      = 16'h0000;
        spi_in_i   = 8'h00;
        spi_done_i = 1'b0;
        spi_busy_i = 1'b0;
        #3;
        chk("rst_csb",   32'(flash_csb_o), 32'd1);
        chk("rst_gnt",   32'(gnt_o),       32'd0);
        chk("rst_done",  32'(done_o),      32'd0);
        chk("rst_tmo",   32'(timeout_o),   32'd0);
        chk("rst_start", 32'(spi_start_o), 32'd0);
        chk("rst_out",   32'(spi_out_o),   32'd0);
        spi_in_i = 8'h96;
        settle();
        chk("in_pass", 32'(in_o), 32'h96);

        tick();
        tick();
        reset_ni = 1'b1;

        // Single owner: req in IDLE, SETUP, then grant.
        tick();
        req_i = 2'b01;
        settle();
        chk("t1_idle_csb", 32'(flash_csb_o), 32'd1);
        chk("t1_idle_gnt", 32'(gnt_o),       32'd0);
        tick();
        settle();
        chk("t1_setup_csb", 32'(flash_csb_o), 32'd0);
        chk("t1_setup_gnt", 32'(gnt_o),       32'd0);
        tick();
        start_i = 2'b10;
        settle();
        chk("t1_gnt",      32'(gnt_o),       32'h1);
        chk("iso_start",   32'(spi_start_o), 32'd0);
        tick();
        start_i    = 2'b01;
        spi_busy_i = 1'b1;
        settle();
        chk("t1_busy_block", 32'(spi_start_o), 32'd0);

        for (int b = 0; b < 4; b++) begin
            tick();
            spi_done_i = 1'b0;
            spi_busy_i = 1'b0;
            start_i    = 2'b01;
            out_i      = {8'hEE, bytes_t1[b]};
            settle();
            chk("t1_start", 32'(spi_start_o), 32'd1);
            chk("t1_out",   32'(spi_out_o),   32'(bytes_t1[b]));
            tick();
            spi_busy_i = 1'b1;
            settle();
            chk("t1_pend_block", 32'(spi_start_o), 32'd0);
            tick();
            start_i    = 2'b10;
            spi_busy_i = 1'b0;
            spi_done_i = 1'b1;
            spi_in_i   = 8'h40 + 8'(b);
            settle();
            chk("t1_done",   32'(done_o),      32'h1);
            chk("iso_nost",  32'(spi_start_o), 32'd0);
            chk("t1_rx",     32'(in_o),        32'h40 + 32'(b));
        end

        tick();
        spi_done_i = 1'b0;
        start_i    = 2'b00;
        req_i      = 2'b00;
        settle();
        chk("t1_drop_csb", 32'(flash_csb_o), 32'd0);
        chk("t1_nodone",   32'(done_o),      32'd0);
        tick();
        settle();
        chk("t1_rel1_csb", 32'(flash_csb_o), 32'd1);
        chk("t1_rel1_gnt", 32'(gnt_o),       32'd0);
        tick();
        settle();
        chk("t1_rel2_csb", 32'(flash_csb_o), 32'd1);
        tick();
        settle();
        chk("t1_idle2_csb", 32'(flash_csb_o), 32'd1);

        // Contention from reset.
        tick();
        reset_ni = 1'b0;
        req_i    = 2'b11;
        settle();
        tick();
        reset_ni = 1'b1;
        settle();
        chk("t2_idle_csb", 32'(flash_csb_o), 32'd1);
        tick();
        settle();
        chk("t2_setup_csb", 32'(flash_csb_o), 32'd0);
        tick();
        settle();
        chk("t2_gnt0", 32'(gnt_o), 32'h1);
        tick();
        start_i = 2'b01;
        out_i   = 16'h00A5;
        settle();
        chk("t2_start1", 32'(spi_start_o), 32'd1);
        chk("t2_out1",   32'(spi_out_o),   32'hA5);
        tick();
        start_i    = 2'b00;
        spi_busy_i = 1'b1;
        settle();
        chk("t2_nost", 32'(spi_start_o), 32'd0);
        tick();
        spi_busy_i = 1'b0;
        spi_done_i = 1'b1;
        start_i    = 2'b01;
        out_i      = 16'h005A;
        settle();
        chk("t2_done_same", 32'(done_o),      32'h1);
        chk("t2_start_same", 32'(spi_start_o), 32'd1);
        chk("t2_out2",      32'(spi_out_o),   32'h5A);
        tick();
        spi_done_i = 1'b0;
        spi_busy_i = 1'b1;
        start_i    = 2'b00;
        settle();
        chk("t2_nost2", 32'(spi_start_o), 32'd0);
        tick();
        spi_busy_i = 1'b0;
        spi_done_i = 1'b1;
        settle();
        chk("t2_done2", 32'(done_o), 32'h1);
        tick();
        spi_done_i = 1'b0;
        req_i      = 2'b10;
        settle();
        chk("t2_drop_gnt", 32'(gnt_o), 32'h1);
        tick();
        settle();
        chk("t2_hold1_csb", 32'(flash_csb_o), 32'd1);
        chk("t2_hold1_gnt", 32'(gnt_o),       32'd0);
        tick();
        settle();
        chk("t2_hold2_csb", 32'(flash_csb_o), 32'd1);
        tick();
        settle();
        chk("t2_setup1_csb", 32'(flash_csb_o), 32'd0);
        chk("t2_setup1_gnt", 32'(gnt_o),       32'd0);
        tick();
        req_i = 2'b01;
        settle();
        chk("t2_gnt1", 32'(gnt_o), 32'h2);
        tick();
        req_i = 2'b11;
        settle();
        chk("t2_r1_csb", 32'(flash_csb_o), 32'd1);
        tick();
        settle();
        chk("t2_r2_csb", 32'(flash_csb_o), 32'd1);
        tick();
        settle();
        chk("t2_setup0_csb", 32'(flash_csb_o), 32'd0);
        tick();
        req_i = 2'b01;
        settle();
        chk("t2_regnt0", 32'(gnt_o),     32'h1);
        chk("t5_tmo_a0", 32'(timeout_o), 32'd0);

        // Timeout: owner 0 never starts.
        for (int k = 1; k < 8; k++) begin
            tick();
            settle();
        end
        chk("t5_tmo_a7", 32'(timeout_o), 32'd0);
        tick();
        settle();
        chk("t5_tmo_a8",  32'(timeout_o), 32'h1);
        chk("t5_gnt_a8",  32'(gnt_o),     32'h1);
        tick();
        settle();
        chk("t5_csb_a9",  32'(flash_csb_o), 32'd1);
        chk("t5_tmo_a9",  32'(timeout_o),   32'd0);
        chk("t5_gnt_a9",  32'(gnt_o),       32'd0);
        for (int k = 0; k < 4; k++) begin
            tick();
            settle();
            chk("t5_masked_csb", 32'(flash_csb_o), 32'd1);
        end
        tick();
        req_i = 2'b00;
        settle();
        tick();
        req_i = 2'b01;
        settle();
        chk("t5_rearb_csb", 32'(flash_csb_o), 32'd1);
        tick();
        settle();
        chk("t5_setup_csb", 32'(flash_csb_o), 32'd0);
        tick();
        settle();
        chk("t5_regnt", 32'(gnt_o), 32'h1);

        // Drain: drop req one cycle after a start.
        tick();
        start_i = 2'b01;
        out_i   = 16'h00C3;
        settle();
        chk("t4_start", 32'(spi_start_o), 32'd1);
        tick();
        start_i    = 2'b00;
        spi_busy_i = 1'b1;
        req_i      = 2'b00;
        settle();
        chk("t4_drop_gnt", 32'(gnt_o), 32'h1);
        tick();
        start_i = 2'b01;
        settle();
        chk("t4_drain_csb",   32'(flash_csb_o), 32'd0);
        chk("t4_drain_gnt",   32'(gnt_o),       32'd0);
        chk("t4_drain_nost",  32'(spi_start_o), 32'd0);
        tick();
        start_i    = 2'b00;
        spi_busy_i = 1'b0;
        spi_done_i = 1'b1;
        settle();
        chk("t4_drain_done", 32'(done_o),      32'h1);
        chk("t4_done_csb",   32'(flash_csb_o), 32'd0);
        tick();
        spi_done_i = 1'b0;
        settle();
        chk("t4_rel_csb",  32'(flash_csb_o), 32'd1);
        chk("t4_rel_done", 32'(done_o),      32'd0);

        // Asynchronous reset in the middle of a byte.
        tick();
        req_i = 2'b01;
        settle();
        tick();
        settle();
        tick();
        settle();
        chk("t6_gnt", 32'(gnt_o), 32'h1);
        tick();
        start_i = 2'b01;
        out_i   = 16'h0077;
        settle();
        chk("t6_start", 32'(spi_start_o), 32'd1);
        tick();
        start_i    = 2'b00;
        spi_busy_i = 1'b1;
        #2;
        reset_ni = 1'b0;
        #1;
        chk("t6_rst_csb",   32'(flash_csb_o), 32'd1);
        chk("t6_rst_gnt",   32'(gnt_o),       32'd0);
        chk("t6_rst_start", 32'(spi_start_o), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
